debounce_pulse: RTL and testbench

//   Debounces one raw mechanical push-button input and emits a single-cycle

---
 rtl/debounce_pulse.sv | 141 ++++++++++++++
 tb/tb_debounce_pulse.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse.sv
// Push-button debouncer producing a one-cycle toggle pulse and a debounced level.
// Define DEBOUNCE_REPEAT_EN to add auto-repeat pulses while the button is held.
module debounce_pulse #(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 25000
) (
    input  logic Clk,
    input  logic rst,
    input  logic btn_in,
    output logic T,
    output logic btn_level
);

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        PRESSED,
        RELEASING
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES >= (2 ** CNT_W)) begin : g_bad_deb
        $error("debounce_pulse: DEBOUNCE_CYCLES out of range");
    end
    if (REPEAT_CYCLES < 2 || REPEAT_CYCLES >= (2 ** CNT_W)) begin : g_bad_rep
        $error("debounce_pulse: REPEAT_CYCLES out of range");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_t;
    logic             w_t_nxt;
    logic             r_level;
    logic             w_level_nxt;

`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [CNT_W-1:0] LP_REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] r_rep;
    logic [CNT_W-1:0] w_rep_nxt;
`endif

    always_ff @(posedge Clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_t     <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_s1    <= btn_in;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_t     <= w_t_nxt;
            r_level <= w_level_nxt;
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    always_ff @(posedge Clk) begin
        if (rst) begin
            r_rep <= '0;
        end else begin
            r_rep <= w_rep_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_t_nxt     = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
        w_rep_nxt   = r_rep;
`endif
        unique case (r_state)
            IDLE: begin
`ifdef DEBOUNCE_REPEAT_EN
                w_rep_nxt = '0;
`endif
                if (r_s2) begin
                    w_state_nxt = ARMING;
                    w_cnt_nxt   = '0;
                end
            end
            ARMING: begin
`ifdef DEBOUNCE_REPEAT_EN
                w_rep_nxt = '0;
`endif
                if (!r_s2) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = PRESSED;
                    w_t_nxt     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                // A release takes priority over a pending repeat pulse.
                if (!r_s2) begin
                    w_state_nxt = RELEASING;
                    w_cnt_nxt   = '0;
                end
`ifdef DEBOUNCE_REPEAT_EN
                else if (r_rep == LP_REP_LAST) begin
                    w_t_nxt   = 1'b1;
                    w_rep_nxt = '0;
                end else begin
                    w_rep_nxt = r_rep + 1'b1;
                end
`endif
            end
            RELEASING: begin
                if (r_s2) begin
                    w_state_nxt = PRESSED;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == RELEASING);
    end

    assign T         = r_t;
    assign btn_level = r_level;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_debounce_pulse;

    localparam int DEB = 4;
    localparam int REPC = 8;
`ifdef DEBOUNCE_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic Clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic T;
    logic btn_level;

    int n_checks = 0;
    int n_errors = 0;
    int e = -1;
    logic th [0:127];
    logic lh [0:127];

    debounce_pulse #(
        .CNT_W          (16),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REPC)
    ) dut (
        .Clk      (Clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .T        (T),
        .btn_level(btn_level)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b);
        btn_in = b;
        @(posedge Clk);
        #1;
        e++;
        if (e >= 0 && e < 128) begin
            th[e] = T;
            lh[e] = btn_level;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        btn_in = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_T", int'(T), 0);
        check("rst_level", int'(btn_level), 0);
        rst = 1'b0;
        e   = -1;
        for (int i = 0; i < 128; i++) begin
            th[i] = 1'b0;
            lh[i] = 1'b0;
        end
    endtask

    function automatic int count_t(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(th[i]);
        return n;
    endfunction

    initial begin
        // 1: clean press held 20 cycles, then release
        do_reset();
        repeat (20) drive(1'b1);
        repeat (10) drive(1'b0);
        check("t1_T_e5", int'(th[5]), 0);
        check("t1_T_e6", int'(th[6]), 1);
        check("t1_T_e7", int'(th[7]), 0);
        check("t1_lvl_e5", int'(lh[5]), 0);
        check("t1_lvl_e6", int'(lh[6]), 1);
        check("t1_cnt_0_19", count_t(0, 19), REP ? 2 : 1);
        check("t1_cnt_20_29", count_t(20, 29), 0);
        check("t1_lvl_e25", int'(lh[25]), 1);
        check("t1_lvl_e26", int'(lh[26]), 0);

        // 2: bouncing press 1,1,0,1,0,1 then stable high
        do_reset();
        drive(1'b1);
        drive(1'b1);
        drive(1'b0);
        drive(1'b1);
        drive(1'b0);
        repeat (16) drive(1'b1);
        check("t2_cnt_0_10", count_t(0, 10), 0);
        check("t2_T_e11", int'(th[11]), 1);
        check("t2_lvl_e10", int'(lh[10]), 0);
        check("t2_lvl_e11", int'(lh[11]), 1);
        check("t2_cnt_0_20", count_t(0, 20), REP ? 2 : 1);

        // 3: too-short press
        do_reset();
        repeat (3) drive(1'b1);
        repeat (13) drive(1'b0);
        check("t3_cnt", count_t(0, 15), 0);
        begin
            int lv = 0;
            for (int i = 0; i <= 15; i++) lv += int'(lh[i]);
            check("t3_lvl", lv, 0);
        end

        // 4: short release glitch while pressed, then real release
        do_reset();
        repeat (10) drive(1'b1);
        repeat (2) drive(1'b0);
        repeat (6) drive(1'b1);
        repeat (10) drive(1'b0);
        check("t4_T_e6", int'(th[6]), 1);
        check("t4_cnt_7_16", count_t(7, 16), 0);
        begin
            int lv = 0;
            for (int i = 6; i <= 23; i++) lv += int'(lh[i]);
            check("t4_lvl_held", lv, 18);
        end
        check("t4_lvl_e24", int'(lh[24]), 0);

        // 5: reset while ARMING, then reset while PRESSED
        do_reset();
        repeat (4) drive(1'b1);
        rst = 1'b1;
        drive(1'b1);
        check("t5a_T", int'(th[4]), 0);
        check("t5a_lvl", int'(lh[4]), 0);
        rst = 1'b0;
        repeat (9) drive(1'b1);
        check("t5a_cnt_5_10", count_t(5, 10), 0);
        check("t5a_T_e11", int'(th[11]), 1);
        check("t5a_lvl_e13", int'(lh[13]), 1);
        rst = 1'b1;
        drive(1'b1);
        check("t5b_T", int'(th[14]), 0);
        check("t5b_lvl", int'(lh[14]), 0);
        rst = 1'b0;
        repeat (8) drive(1'b1);
        check("t5b_cnt_15_20", count_t(15, 20), 0);
        check("t5b_T_e21", int'(th[21]), 1);
        check("t5b_lvl_e21", int'(lh[21]), 1);

        // 6: long hold, auto-repeat when enabled
        do_reset();
        repeat (40) drive(1'b1);
        check("t6_T_e6", int'(th[6]), 1);
        check("t6_T_e14", int'(th[14]), REP);
        check("t6_T_e22", int'(th[22]), REP);
        check("t6_T_e30", int'(th[30]), REP);
        check("t6_T_e38", int'(th[38]), REP);
        check("t6_T_e13", int'(th[13]), 0);
        check("t6_cnt", count_t(0, 39), REP ? 5 : 1);
        check("t6_lvl_e39", int'(lh[39]), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
